// File: rtl/mdr_ext_unit.sv
// mdr_ext_unit: memory data register with bus load, handshaked memory read and lane extraction
module mdr_ext_unit #(
  parameter int DATA_W  = 32,
  parameter int OFF_W   = 2,
  parameter int TIMEOUT = 15,
  parameter int TO_W    = 4
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              mdr_in,
  input  logic              read_start,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [OFF_W-1:0]  byte_off,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              mem_req,
  output logic [DATA_W-1:0] mdr_out,
  output logic              busy,
  output logic              rd_done,
  output logic              rd_err
);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t            state;
  logic [TO_W-1:0]   cnt;
  logic [1:0]        size_q;
  logic              sign_q;
  logic [OFF_W-1:0]  off_q;
  logic [7:0]        lane_b;
  logic [15:0]       lane_h;
  logic [DATA_W-1:0] ext;
  // misaligned halfwords round down: the offset LSB never reaches the lane select
  assign lane_b = mem_rdata[8*off_q +: 8];
  assign lane_h = mem_rdata[16*off_q[OFF_W-1:1] +: 16];
  always_comb
    ext = size_q == 2'b00 ? {{(DATA_W-8){sign_q & lane_b[7]}}, lane_b} :
          size_q == 2'b01 ? {{(DATA_W-16){sign_q & lane_h[15]}}, lane_h} : mem_rdata;
  always_ff @(posedge clk or posedge clr)
    if (clr) begin
      state   <= IDLE;
      mem_req <= 1'b0;
      busy    <= 1'b0;
      rd_done <= 1'b0;
      rd_err  <= 1'b0;
      cnt     <= '0;
      mdr_out <= '0;
      size_q  <= '0;
      sign_q  <= 1'b0;
      off_q   <= '0;
    end else begin
      rd_done <= 1'b0;
      if (state == IDLE) begin
        if (mdr_in) mdr_out <= bus_in;
        if (read_start) begin
          size_q  <= size;
          sign_q  <= sign_ext;
          off_q   <= byte_off;
          cnt     <= '0;
          rd_err  <= 1'b0;
          state   <= WAIT;
          mem_req <= 1'b1;
          busy    <= 1'b1;
        end
      end else if (mem_ack) begin
        mdr_out <= ext;
        rd_done <= 1'b1;
        state   <= IDLE;
        mem_req <= 1'b0;
        busy    <= 1'b0;
      end else if (cnt == TO_W'(TIMEOUT-1)) begin
        rd_err  <= 1'b1;
        state   <= IDLE;
        mem_req <= 1'b0;
        busy    <= 1'b0;
      end else cnt <= cnt + 1'b1;
    end
endmodule

// File: tb/tb_mdr_ext_unit.sv
// tb_mdr_ext_unit: directed vectors for mdr_ext_unit with hand-computed results
module tb_mdr_ext_unit;
  logic        clk = 1'b0;
  logic        clr;
  logic [31:0] bus_in;
  logic        mdr_in;
  logic        read_start;
  logic [1:0]  size;
  logic        sign_ext;
  logic [1:0]  byte_off;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        mem_req;
  logic [31:0] mdr_out;
  logic        busy;
  logic        rd_done;
  logic        rd_err;
  int errs = 0;
  int checks = 0;
  mdr_ext_unit dut (
    .clk(clk), .clr(clr), .bus_in(bus_in), .mdr_in(mdr_in), .read_start(read_start),
    .size(size), .sign_ext(sign_ext), .byte_off(byte_off), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .mem_req(mem_req), .mdr_out(mdr_out), .busy(busy),
    .rd_done(rd_done), .rd_err(rd_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic do_read(input string tag, input logic [1:0] sz, input logic sx,
                         input logic [1:0] off, input logic [31:0] rd, input int lag,
                         input logic [31:0] exp);
    @(negedge clk);
    size = sz; sign_ext = sx; byte_off = off; read_start = 1'b1;
    @(negedge clk);
    read_start = 1'b0; byte_off = ~off;
    chk({tag, "_req"}, {31'b0, mem_req}, 32'd1);
    chk({tag, "_busy"}, {31'b0, busy}, 32'd1);
    repeat (lag) @(negedge clk);
    mem_rdata = rd; mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0; mem_rdata = 32'h0;
    chk({tag, "_data"}, mdr_out, exp);
    chk({tag, "_done"}, {31'b0, rd_done}, 32'd1);
    chk({tag, "_reqlow"}, {31'b0, mem_req}, 32'd0);
    @(negedge clk);
    chk({tag, "_done1"}, {31'b0, rd_done}, 32'd0);
  endtask
  initial begin
    int n;
    clr = 1'b1; bus_in = '0; mdr_in = 1'b0; read_start = 1'b0; size = '0;
    sign_ext = 1'b0; byte_off = '0; mem_rdata = '0; mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_mdr", mdr_out, 32'h0);
    chk("rst_req", {31'b0, mem_req}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    clr = 1'b0;
    @(negedge clk);
    bus_in = 32'hDEADBEEF; mdr_in = 1'b1;
    @(negedge clk);
    mdr_in = 1'b0;
    chk("busload", mdr_out, 32'hDEADBEEF);
    chk("busload_req", {31'b0, mem_req}, 32'd0);
    do_read("sbyte", 2'b00, 1'b1, 2'd2, 32'h12F45678, 2, 32'hFFFFFFF4);
    do_read("ubyte", 2'b00, 1'b0, 2'd2, 32'h12F45678, 2, 32'h000000F4);
    do_read("shalf", 2'b01, 1'b1, 2'd3, 32'h80017FFF, 1, 32'hFFFF8001);
    do_read("uhalf", 2'b01, 1'b0, 2'd0, 32'h8001F00F, 0, 32'h0000F00F);
    do_read("pbyte", 2'b00, 1'b1, 2'd0, 32'hAAAAAA7F, 0, 32'h0000007F);
    do_read("word", 2'b10, 1'b1, 2'd1, 32'h89ABCDEF, 4, 32'h89ABCDEF);
    // timeout: count cycles mem_req stays high with no ack
    @(negedge clk);
    size = 2'b10; read_start = 1'b1;
    @(negedge clk);
    read_start = 1'b0;
    n = 0;
    for (int i = 0; i < 40 && mem_req; i++) begin
      n++;
      @(negedge clk);
    end
    chk("to_cycles", n, 32'd15);
    chk("to_err", {31'b0, rd_err}, 32'd1);
    chk("to_mdr", mdr_out, 32'h89ABCDEF);
    chk("to_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    chk("to_errhold", {31'b0, rd_err}, 32'd1);
    read_start = 1'b1;
    @(negedge clk);
    read_start = 1'b0;
    chk("to_errclr", {31'b0, rd_err}, 32'd0);
    repeat (14) @(negedge clk);
    chk("edge_req", {31'b0, mem_req}, 32'd1);
    mem_rdata = 32'hCAFEF00D; mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("edge_data", mdr_out, 32'hCAFEF00D);
    chk("edge_err", {31'b0, rd_err}, 32'd0);
    chk("edge_done", {31'b0, rd_done}, 32'd1);
    // collisions
    @(negedge clk);
    bus_in = 32'h11112222; mdr_in = 1'b1; read_start = 1'b1; size = 2'b10;
    @(negedge clk);
    mdr_in = 1'b0; read_start = 1'b0;
    chk("col_bus", mdr_out, 32'h11112222);
    chk("col_busy", {31'b0, busy}, 32'd1);
    bus_in = 32'h33334444; mdr_in = 1'b1; read_start = 1'b1;
    @(negedge clk);
    mdr_in = 1'b0; read_start = 1'b0;
    chk("col_wait_ld", mdr_out, 32'h11112222);
    mem_rdata = 32'hABCD0123; mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("col_rd", mdr_out, 32'hABCD0123);
    chk("col_idle", {31'b0, busy}, 32'd0);
    mem_rdata = 32'h55555555; mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("idle_ack_mdr", mdr_out, 32'hABCD0123);
    chk("idle_ack_done", {31'b0, rd_done}, 32'd0);
    chk("idle_ack_req", {31'b0, mem_req}, 32'd0);
    // asynchronous reset in the middle of a read
    read_start = 1'b1;
    @(negedge clk);
    read_start = 1'b0;
    chk("ar_busy", {31'b0, busy}, 32'd1);
    #2 clr = 1'b1;
    #1;
    chk("ar_req", {31'b0, mem_req}, 32'd0);
    chk("ar_busy0", {31'b0, busy}, 32'd0);
    chk("ar_mdr", mdr_out, 32'h0);
    chk("ar_done", {31'b0, rd_done}, 32'd0);
    chk("ar_err", {31'b0, rd_err}, 32'd0);
    @(negedge clk);
    clr = 1'b0;
    mem_rdata = 32'h77777777; mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("ar_noload", mdr_out, 32'h0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
